// File: rtl/seg7_disp_src.sv
// seg7_disp_src: memory-mapped source of the 32-bit hex display word.
// CPU display register, retire counter and a debounced view-step button.
module seg7_disp_src #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          DEB_CNT   = 1_000_000,
  parameter int          DEB_W     = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_be,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  input  logic [31:0] dbg_pc,
  input  logic [31:0] dbg_instr,
  input  logic        dbg_retire,
  input  logic        btn_step,
  output logic [31:0] o_data,
  output logic [1:0]  o_src
);

  localparam logic [29:0] A_DISP = BASE_ADDR[31:2];
  localparam logic [29:0] A_SRC  = A_DISP + 30'd1;
  localparam logic [29:0] A_RET  = A_DISP + 30'd2;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

  logic [31:0]      disp_q, disp_d;
  logic [1:0]       src_q, src_d;
  logic [31:0]      ret_q, ret_d;
  logic [31:0]      o_data_q, o_data_d;
  logic [1:0]       o_src_q, o_src_d;
  logic             ack_q, ack_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q, deb_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  logic        hit_disp;
  logic        hit_src;
  logic        hit_ret;
  logic        req;
  logic        wr;
  logic        step;
  logic [31:0] rd_val;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^bus_addr[1:0];

  always_comb begin
    hit_disp = (bus_addr[31:2] == A_DISP);
    hit_src  = (bus_addr[31:2] == A_SRC);
    hit_ret  = (bus_addr[31:2] == A_RET);
    req = (bus_we | bus_re) & (hit_disp | hit_src | hit_ret);
    wr  = bus_we;
  end

  // Level is accepted on the DEB_CNT-th consecutive differing cycle.
  always_comb begin
    sync1_d = btn_step;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    step    = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == DEB_LAST) begin
        deb_d = sync2_q;
        step  = sync2_q;
      end else begin
        cnt_d = cnt_q + DEB_W'(1);
      end
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      hit_disp: rd_val = disp_q;
      hit_src:  rd_val = {30'd0, src_q};
      hit_ret:  rd_val = ret_q;
      default:  rd_val = '0;
    endcase
    ack_d   = req;
    rdata_d = req ? rd_val : '0;
  end

  always_comb begin
    disp_d = disp_q;
    for (int i = 0; i < 4; i++) begin
      if (wr && hit_disp && bus_be[i]) begin
        disp_d[8*i +: 8] = bus_wdata[8*i +: 8];
      end
    end
  end

  // A bus write to src overrides a coincident step.
  always_comb begin
    src_d = src_q;
    if (step) begin
      src_d = src_q + 2'd1;
    end
    if (wr && hit_src && bus_be[0]) begin
      src_d = bus_wdata[1:0];
    end
  end

  always_comb begin
    ret_d = ret_q;
    if (dbg_retire) begin
      ret_d = ret_q + 32'd1;
    end
    if (wr && hit_ret && (bus_be != 4'd0)) begin
      ret_d = '0;
    end
  end

  always_comb begin
    o_data_d = '0;
    unique case (src_q)
      2'd0:    o_data_d = disp_q;
      2'd1:    o_data_d = dbg_pc;
      2'd2:    o_data_d = dbg_instr;
      default: o_data_d = ret_q;
    endcase
    o_src_d = src_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q   <= '0;
      src_q    <= '0;
      ret_q    <= '0;
      o_data_q <= '0;
      o_src_q  <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      deb_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      disp_q   <= disp_d;
      src_q    <= src_d;
      ret_q    <= ret_d;
      o_data_q <= o_data_d;
      o_src_q  <= o_src_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign bus_ack   = ack_q;
  assign o_data    = o_data_q;
  assign o_src     = o_src_q;

endmodule

// File: tb/tb_seg7_disp_src.sv
// tb_seg7_disp_src: randomized bench for seg7_disp_src against
// a cycle-level behavioural model of the display source.
module tb_seg7_disp_src;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [3:0]  bus_be = '0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] dbg_pc = '0;
  logic [31:0] dbg_instr = '0;
  logic        dbg_retire = 1'b0;
  logic        btn_step = 1'b0;
  logic [31:0] o_data;
  logic [1:0]  o_src;

  always #5 clk = ~clk;

  seg7_disp_src #(
    .BASE_ADDR(BASE),
    .DEB_CNT(DC),
    .DEB_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_be(bus_be),
    .bus_we(bus_we),
    .bus_re(bus_re),
    .bus_rdata(bus_rdata),
    .bus_ack(bus_ack),
    .dbg_pc(dbg_pc),
    .dbg_instr(dbg_instr),
    .dbg_retire(dbg_retire),
    .btn_step(btn_step),
    .o_data(o_data),
    .o_src(o_src)
  );

  logic [31:0] m_disp = '0, m_ret = '0;
  logic [31:0] m_odata = '0, m_rdata = '0;
  logic [1:0]  m_src = '0, m_osrc = '0;
  logic        m_ack = 0, m_s1 = 0, m_s2 = 0;
  logic        m_lvl = 0;
  int          m_run = 0;
  int          nvec = 0, nerr = 0;

  function automatic int region(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (w == BASE) return 0;
    if (w == BASE + 32'd4) return 1;
    if (w == BASE + 32'd8) return 2;
    return -1;
  endfunction

  function automatic logic will_step();
    return m_s2 && !m_lvl && (m_run + 1 == DC);
  endfunction

  function automatic logic [66:0] obsv();
    return {bus_ack, bus_rdata, o_data, o_src};
  endfunction

  function automatic logic [66:0] expv();
    return {m_ack, m_rdata, m_odata, m_osrc};
  endfunction

  task automatic cyc();
    logic [31:0] nd, nr, pre, nrd, nod;
    logic [1:0] ns, nos;
    logic nack, nlvl, n1, n2, req;
    int nrun, rg;
    nd = 0; nr = 0; nrd = 0; nod = 0; ns = 0; nos = 0;
    nack = 0; nlvl = 0; n1 = 0; n2 = 0; nrun = 0;
    if (!rst) begin
      rg = region(bus_addr);
      req = (bus_we || bus_re) && rg >= 0;
      case (rg)
        0: pre = m_disp;
        1: pre = {30'd0, m_src};
        2: pre = m_ret;
        default: pre = 0;
      endcase
      nrd = req ? pre : 0;
      nack = req;
      case (m_src)
        0: nod = m_disp;
        1: nod = dbg_pc;
        2: nod = dbg_instr;
        default: nod = m_ret;
      endcase
      nos = m_src;
      nlvl = m_lvl;
      ns = m_src;
      if (m_s2 != m_lvl) begin
        nrun = m_run + 1;
        if (nrun == DC) begin
          nlvl = m_s2;
          nrun = 0;
          if (m_s2) ns = m_src + 2'd1;
        end
      end
      nd = m_disp;
      for (int i = 0; i < 4; i++)
        if (bus_we && rg == 0 && bus_be[i])
          nd[8*i +: 8] = bus_wdata[8*i +: 8];
      if (bus_we && rg == 1 && bus_be[0])
        ns = bus_wdata[1:0];
      nr = m_ret + (dbg_retire ? 32'd1 : 32'd0);
      if (bus_we && rg == 2 && bus_be != 0) nr = 0;
      n1 = btn_step;
      n2 = m_s1;
    end
    @(posedge clk);
    #1;
    m_disp = nd; m_ret = nr; m_rdata = nrd;
    m_odata = nod; m_src = ns; m_osrc = nos;
    m_ack = nack; m_lvl = nlvl; m_run = nrun;
    m_s1 = n1; m_s2 = n2;
  endtask

  task automatic idle();
    bus_we = 0; bus_re = 0; bus_be = 0;
    bus_addr = 0; bus_wdata = 0; dbg_retire = 0;
  endtask

  task automatic put(input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0] be,
                     input logic we, input logic re);
    bus_addr = a; bus_wdata = d; bus_be = be;
    bus_we = we; bus_re = re;
  endtask

  task automatic test_reset();
    rst = 1;
    put($urandom, $urandom, 4'hF, 1, 1);
    btn_step = 1;
    cyc(); cyc();
    rst = 0; idle(); btn_step = 0;
    nvec++;
    if (obsv() !== 67'd0) begin
      nerr++;
      $display("FAIL reset got %h exp 0", obsv());
    end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_disp_rw();
    put(BASE, 32'h1234_5678, 4'hF, 1, 0);
    cyc(); idle();
    nvec++;
    if (bus_ack !== 1'b1 || obsv() !== expv()) begin
      nerr++;
      $display("FAIL st_ack got %h exp %h", obsv(), expv());
    end
    cyc();
    nvec++;
    if (o_data !== 32'h1234_5678) begin
      nerr++;
      $display("FAIL st_odata got %h exp 12345678", o_data);
    end
    put(BASE + 32'd2, 0, 0, 0, 1);
    cyc(); idle();
    nvec++;
    if (bus_ack !== 1 || bus_rdata !== 32'h1234_5678) begin
      nerr++;
      $display("FAIL ld_disp got %b %h exp 1 12345678",
               bus_ack, bus_rdata);
    end
    cyc();
    nvec++;
    if (bus_ack !== 0 || bus_rdata !== 0) begin
      nerr++;
      $display("FAIL ack_pulse got %b %h exp 0 0",
               bus_ack, bus_rdata);
    end
    put(BASE, 32'hAABB_CCDD, 4'b0101, 1, 0);
    cyc(); idle(); cyc(); cyc();
    nvec++;
    if (o_data !== 32'h12BB_56DD) begin
      nerr++;
      $display("FAIL be_merge got %h exp 12bb56dd", o_data);
    end
    put(BASE + 32'd12, 32'hDEAD_BEEF, 4'hF, 1, 1);
    cyc(); idle();
    nvec++;
    if (bus_ack !== 0 || bus_rdata !== 0) begin
      nerr++;
      $display("FAIL miss_ack got %b %h exp 0 0",
               bus_ack, bus_rdata);
    end
    cyc(); cyc();
    nvec++;
    if (o_data !== 32'h12BB_56DD || obsv() !== expv()) begin
      nerr++;
      $display("FAIL miss_nochg got %h exp 12bb56dd", o_data);
    end
  endtask

  task automatic test_button();
    int chg;
    logic [1:0] prev;
    chg = 0;
    dbg_pc = $urandom;
    prev = o_src;
    for (int i = 0; i < 24; i++) begin
      btn_step = (i < 4) ? (i % 2 == 0) : (i < 14);
      cyc();
      nvec++;
      if (obsv() !== expv()) begin
        nerr++;
        $display("FAIL bounce c%0d got %h exp %h",
                 i, obsv(), expv());
      end
      if (o_src !== prev) chg++;
      prev = o_src;
    end
    nvec++;
    if (chg != 1 || o_src !== 2'd1 || o_data !== dbg_pc) begin
      nerr++;
      $display("FAIL bounce_step got chg=%0d src=%0d exp 1 1",
               chg, o_src);
    end
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 16; i++) begin
        btn_step = (i < 8);
        cyc();
        nvec++;
        if (obsv() !== expv()) begin
          nerr++;
          $display("FAIL press p%0d c%0d got %h exp %h",
                   p, i, obsv(), expv());
        end
      end
      nvec++;
      if (o_src !== 2'(p + 2)) begin
        nerr++;
        $display("FAIL wrap p%0d got %0d exp %0d",
                 p, o_src, 2'(p + 2));
      end
    end
  endtask

  task automatic test_bus_beats_step();
    logic got;
    got = 0;
    btn_step = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (will_step()) begin
        put(BASE + 32'd4, 32'h0000_0003, 4'b0001, 1, 0);
        got = 1;
      end
      cyc();
      idle();
    end
    cyc(); cyc();
    nvec++;
    if (!got || o_src !== 2'd3 || o_data !== m_ret) begin
      nerr++;
      $display("FAIL bus_wins got %0d src=%0d exp 1 src=3",
               got, o_src);
    end
    btn_step = 0;
    for (int i = 0; i < 10; i++) cyc();
  endtask

  task automatic test_retire();
    put(BASE + 32'd8, 0, 4'hF, 1, 0);
    cyc(); idle();
    for (int i = 0; i < 5; i++) begin
      dbg_retire = 1; cyc();
      dbg_retire = 0; cyc();
    end
    put(BASE + 32'd8, 0, 0, 0, 1);
    cyc(); idle();
    nvec++;
    if (bus_ack !== 1 || bus_rdata !== 32'd5) begin
      nerr++;
      $display("FAIL ret5 got %b %0d exp 1 5", bus_ack, bus_rdata);
    end
    put(BASE + 32'd8, 0, 4'b1000, 1, 0);
    dbg_retire = 1;
    cyc(); idle();
    put(BASE + 32'd8, 0, 0, 0, 1);
    cyc(); idle();
    nvec++;
    if (bus_rdata !== 0 || obsv() !== expv()) begin
      nerr++;
      $display("FAIL clr_wins got %0d exp 0", bus_rdata);
    end
    force dut.ret_q = 32'hFFFF_FFFF;
    #1;
    release dut.ret_q;
    m_ret = 32'hFFFF_FFFF;
    put(BASE + 32'd8, 0, 0, 0, 1);
    cyc(); idle();
    nvec++;
    if (bus_rdata !== 32'hFFFF_FFFF) begin
      nerr++;
      $display("FAIL preload got %h exp ffffffff", bus_rdata);
    end
    dbg_retire = 1;
    cyc(); idle();
    put(BASE + 32'd8, 0, 0, 0, 1);
    cyc(); idle();
    nvec++;
    if (bus_rdata !== 0 || obsv() !== expv()) begin
      nerr++;
      $display("FAIL ret_wrap got %h exp 0", bus_rdata);
    end
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 4);
      bus_addr = (k < 4) ? BASE + 32'(4 * k) + 32'($urandom_range(0, 3))
                         : $urandom;
      bus_wdata = $urandom;
      bus_be = 4'($urandom);
      bus_we = ($urandom_range(0, 2) == 0);
      bus_re = ($urandom_range(0, 2) == 0);
      dbg_retire = 1'($urandom);
      dbg_pc = $urandom;
      dbg_instr = $urandom;
      if ($urandom_range(0, 5) == 0) btn_step = ~btn_step;
      cyc();
      nvec++;
      if (obsv() !== expv()) begin
        nerr++;
        $display("FAIL rand c%0d got %h exp %h",
                 i, obsv(), expv());
      end
    end
    idle();
    btn_step = 0;
    for (int i = 0; i < 10; i++) cyc();
  endtask

  task automatic test_reset_mid();
    put(BASE + 32'd4, 32'd2, 4'b0001, 1, 0);
    cyc();
    put(BASE, 32'hC0FF_EE01, 4'hF, 1, 0);
    cyc(); idle(); cyc();
    nvec++;
    if (o_src !== 2'd2) begin
      nerr++;
      $display("FAIL pre_rst src got %0d exp 2", o_src);
    end
    btn_step = 1;
    cyc(); cyc(); cyc();
    rst = 1; cyc(); rst = 0;
    nvec++;
    if (obsv() !== 67'd0) begin
      nerr++;
      $display("FAIL mid_rst got %h exp 0", obsv());
    end
    for (int i = 1; i <= DC + 5; i++) begin
      cyc();
      nvec++;
      if (obsv() !== expv()) begin
        nerr++;
        $display("FAIL post_rst c%0d got %h exp %h",
                 i, obsv(), expv());
      end
      if (i == DC + 2 || i == DC + 3) begin
        nvec++;
        if (o_src !== ((i == DC + 3) ? 2'd1 : 2'd0)) begin
          nerr++;
          $display("FAIL rst_deb c%0d got %0d", i, o_src);
        end
      end
    end
    btn_step = 0;
  endtask

  initial begin
    test_reset();
    test_disp_rw();
    test_button();
    test_bus_beats_step();
    test_retire();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
